mod_count_monitor: RTL and testbench



---
 rtl/mod_count_monitor.sv | 186 ++++++++++++++++++
 tb/tb_mod_count_monitor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mod_count_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : mod_count_monitor
//  Purpose  : Downstream checker for a modulo-MOD divider counter. Samples
//             the divider count every clk, verifies the 0,1,..,MOD-1,0
//             sequence, declares lock after LOCK_LEN consecutive good steps,
//             pulses once per completed period while locked, counts periods
//             (saturating) and captures the first fault seen while locked.
//  Ports    :
//    clk         in   1    system clock (same clock as the divider)
//    reset_L     in   1    asynchronous active-low reset
//    count_in    in   CW   divider count, synchronous to clk
//    clr         in   1    synchronous clear of FSM, flags and period count
//    locked      out  1    high while the FSM is LOCKED
//    wrap_pulse  out  1    one-cycle pulse per completed period while LOCKED
//    period_cnt  out  PCW  completed periods; saturates at all-ones
//    err_sticky  out  1    first fault while LOCKED; held until clr/reset
//    err_code    out  2    first-fault code: 0 none, 1 illegal, 2 skip, 3 stall
//  Revision : 1.0  initial release
// ============================================================================
module mod_count_monitor #(
  parameter int MOD      = 3,
  parameter int CW       = 2,
  parameter int LOCK_LEN = 4,
  parameter int PCW      = 16
) (
  input  logic           clk,
  input  logic           reset_L,
  input  logic [CW-1:0]  count_in,
  input  logic           clr,
  output logic           locked,
  output logic           wrap_pulse,
  output logic [PCW-1:0] period_cnt,
  output logic           err_sticky,
  output logic [1:0]     err_code
);

  localparam int            GW       = $clog2(LOCK_LEN + 1);
  localparam logic [CW-1:0] LAST     = CW'(MOD - 1);
  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_LEN);

  localparam logic [1:0] CODE_ILLEGAL = 2'd1;
  localparam logic [1:0] CODE_SKIP    = 2'd2;
  localparam logic [1:0] CODE_STALL   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACQ    = 2'd1,
    S_LOCKED = 2'd2,
    S_FAULT  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  prev_q;
  logic [GW-1:0]  good_q, good_d;
  logic           locked_q;
  logic           wrap_q, wrap_d;
  logic [PCW-1:0] pcnt_q, pcnt_d;
  logic           sticky_q, sticky_d;
  logic [1:0]     code_q, code_d;

  // --------------------------------------------------------------------------
  // Step classification of the current sample against the previous one
  // --------------------------------------------------------------------------
  logic [CW-1:0] expect_w;
  logic          illegal_w;
  logic          good_w;
  logic          stall_w;
  logic          wrap_w;
  logic [1:0]    code_w;

  always_comb begin
    expect_w  = (prev_q == LAST) ? '0 : prev_q + CW'(1);
    illegal_w = (32'(count_in) >= 32'(MOD));
    good_w    = !illegal_w && (count_in == expect_w);
    // With MOD==1 the expected value equals prev, so good must win over stall.
    stall_w   = !illegal_w && !good_w && (count_in == prev_q);
    wrap_w    = good_w && (prev_q == LAST);
    if (illegal_w) begin
      code_w = CODE_ILLEGAL;
    end else if (stall_w) begin
      code_w = CODE_STALL;
    end else begin
      code_w = CODE_SKIP;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    wrap_d   = 1'b0;
    pcnt_d   = pcnt_q;
    sticky_d = sticky_q;
    code_d   = code_q;

    unique case (state_q)
      S_IDLE: begin
        // prev is not meaningful on this edge, so no check is made.
        state_d = S_ACQ;
        good_d  = '0;
      end
      S_ACQ: begin
        if (good_w) begin
          if (good_q + GW'(1) == GOOD_MAX) begin
            state_d = S_LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + GW'(1);
          end
        end else begin
          // Errors before lock only restart acquisition.
          good_d = '0;
        end
      end
      S_LOCKED: begin
        if (good_w) begin
          if (wrap_w) begin
            wrap_d = 1'b1;
            if (pcnt_q != '1) begin
              pcnt_d = pcnt_q + PCW'(1);
            end
          end
        end else begin
          state_d  = S_FAULT;
          sticky_d = 1'b1;
          // Only the first fault is recorded.
          if (!sticky_q) begin
            code_d = code_w;
          end
        end
      end
      S_FAULT: begin
        // Frozen until clr or reset.
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // clr overrides any error or wrap detected in the same cycle.
    if (clr) begin
      state_d  = S_IDLE;
      good_d   = '0;
      wrap_d   = 1'b0;
      pcnt_d   = '0;
      sticky_d = 1'b0;
      code_d   = 2'd0;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q  <= S_IDLE;
      prev_q   <= '0;
      good_q   <= '0;
      locked_q <= 1'b0;
      wrap_q   <= 1'b0;
      pcnt_q   <= '0;
      sticky_q <= 1'b0;
      code_q   <= 2'd0;
    end else begin
      state_q  <= state_d;
      prev_q   <= count_in;
      good_q   <= good_d;
      locked_q <= (state_d == S_LOCKED);
      wrap_q   <= wrap_d;
      pcnt_q   <= pcnt_d;
      sticky_q <= sticky_d;
      code_q   <= code_d;
    end
  end

  assign locked     = locked_q;
  assign wrap_pulse = wrap_q;
  assign period_cnt = pcnt_q;
  assign err_sticky = sticky_q;
  assign err_code   = code_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_count_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mod_count_monitor
//  Purpose  : Scoreboard bench for mod_count_monitor. Instance A uses the
//             default parameters; instance B uses PCW=4 for saturation.
//             Stimulus pushes the expected post-edge outputs into a queue;
//             a monitor pops one entry per clock and compares.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mod_count_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A (PCW=16)
  logic        rst_a, clr_a;
  logic [1:0]  cin_a;
  logic        lock_a, wrap_a, sticky_a;
  logic [15:0] pcnt_a;
  logic [1:0]  code_a;

  // Instance B (PCW=4)
  logic        rst_b, clr_b;
  logic [1:0]  cin_b;
  logic        lock_b, wrap_b, sticky_b;
  logic [3:0]  pcnt_b;
  logic [1:0]  code_b;

  mod_count_monitor #(.MOD(3), .CW(2), .LOCK_LEN(4), .PCW(16)) dut_a (
    .clk        (clk),
    .reset_L    (rst_a),
    .count_in   (cin_a),
    .clr        (clr_a),
    .locked     (lock_a),
    .wrap_pulse (wrap_a),
    .period_cnt (pcnt_a),
    .err_sticky (sticky_a),
    .err_code   (code_a)
  );

  mod_count_monitor #(.MOD(3), .CW(2), .LOCK_LEN(4), .PCW(4)) dut_b (
    .clk        (clk),
    .reset_L    (rst_b),
    .count_in   (cin_b),
    .clr        (clr_b),
    .locked     (lock_b),
    .wrap_pulse (wrap_b),
    .period_cnt (pcnt_b),
    .err_sticky (sticky_b),
    .err_code   (code_b)
  );

  typedef struct {
    bit          sel;
    logic [20:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [20:0] pack(input logic l, input logic w, input logic [15:0] p,
                                       input logic s, input logic [1:0] c);
    return {l, w, p, s, c};
  endfunction

  function automatic logic [20:0] act_a();
    return pack(lock_a, wrap_a, pcnt_a, sticky_a, code_a);
  endfunction

  function automatic logic [20:0] act_b();
    return pack(lock_b, wrap_b, {12'd0, pcnt_b}, sticky_b, code_b);
  endfunction

  task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got L=%b W=%b P=%0d S=%b C=%0d, expected L=%b W=%b P=%0d S=%b C=%0d",
               name, act[20], act[19], act[18:3], act[2], act[1:0],
               exp[20], exp[19], exp[18:3], exp[2], exp[1:0]);
    end
  endtask

  // Monitor: outputs are presented every clock; compare #1 after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, e.sel ? act_b() : act_a(), e.exp);
    end
  end

  // Drive one sample on the falling edge and queue the outputs expected
  // after the following rising edge.
  task automatic step(input bit sel, input logic [1:0] cin, input logic c,
                      input logic l, input logic w, input int p,
                      input logic s, input logic [1:0] code, input string name);
    exp_t e;
    @(negedge clk);
    if (sel) begin
      cin_b = cin;
      clr_b = c;
    end else begin
      cin_a = cin;
      clr_a = c;
    end
    e.sel  = sel;
    e.exp  = pack(l, w, 16'(p), s, code);
    e.name = name;
    sb.push_back(e);
  endtask

  initial begin
    int p;
    rst_a = 1'b0; clr_a = 1'b0; cin_a = 2'd0;
    rst_b = 1'b0; clr_b = 1'b0; cin_b = 2'd0;
    #12;
    check("reset_a", act_a(), 21'd0);
    check("reset_b", act_b(), 21'd0);

    @(posedge clk);
    #2 rst_a = 1'b1;

    // Acquisition and lock: 1 sample + 4 good steps
    //        sel cin clr L  W  P  S  C
    step(0, 2'd0, 0, 0, 0, 0, 0, 0, "t1_idle");
    step(0, 2'd1, 0, 0, 0, 0, 0, 0, "t1_g1");
    step(0, 2'd2, 0, 0, 0, 0, 0, 0, "t1_g2");
    step(0, 2'd0, 0, 0, 0, 0, 0, 0, "t1_g3_nowrap");
    step(0, 2'd1, 0, 1, 0, 0, 0, 0, "t1_lock");
    step(0, 2'd2, 0, 1, 0, 0, 0, 0, "t1_l2");
    step(0, 2'd0, 0, 1, 1, 1, 0, 0, "t1_wrap1");
    step(0, 2'd1, 0, 1, 0, 1, 0, 0, "t1_l1");
    step(0, 2'd2, 0, 1, 0, 1, 0, 0, "t1_l2b");
    step(0, 2'd0, 0, 1, 1, 2, 0, 0, "t1_wrap2");
    step(0, 2'd1, 0, 1, 0, 2, 0, 0, "t1_l1c");
    step(0, 2'd2, 0, 1, 0, 2, 0, 0, "t1_l2c");
    step(0, 2'd0, 0, 1, 1, 3, 0, 0, "t1_wrap3");
    // Illegal value while locked, then a later skip keeps code 1
    step(0, 2'd3, 0, 0, 0, 3, 1, 1, "t2_illegal");
    step(0, 2'd0, 0, 0, 0, 3, 1, 1, "t2_fault_hold");
    step(0, 2'd2, 0, 0, 0, 3, 1, 1, "t2_skip_keeps1");
    // clr together with a bad sample (stall) in FAULT
    step(0, 2'd2, 1, 0, 0, 0, 0, 0, "t5_clr_wins");
    step(0, 2'd0, 0, 0, 0, 0, 0, 0, "t5_idle");
    step(0, 2'd1, 0, 0, 0, 0, 0, 0, "t5_g1");
    step(0, 2'd2, 0, 0, 0, 0, 0, 0, "t5_g2");
    step(0, 2'd0, 0, 0, 0, 0, 0, 0, "t5_g3");
    step(0, 2'd1, 0, 1, 0, 0, 0, 0, "t5_relock");
    step(0, 2'd2, 0, 1, 0, 0, 0, 0, "t5_l2");
    step(0, 2'd0, 0, 1, 1, 1, 0, 0, "t5_wrap");
    // Skip 0->2 while locked
    step(0, 2'd2, 0, 0, 0, 1, 1, 2, "t3_skip");
    step(0, 2'd0, 0, 0, 0, 1, 1, 2, "t3_frozen");
    step(0, 2'd0, 0, 0, 0, 1, 1, 2, "t3_stall_keeps2");
    // Stall run
    step(0, 2'd1, 1, 0, 0, 0, 0, 0, "t3_clr");
    step(0, 2'd2, 0, 0, 0, 0, 0, 0, "t3s_idle");
    step(0, 2'd0, 0, 0, 0, 0, 0, 0, "t3s_g1");
    step(0, 2'd1, 0, 0, 0, 0, 0, 0, "t3s_g2");
    step(0, 2'd2, 0, 0, 0, 0, 0, 0, "t3s_g3");
    step(0, 2'd0, 0, 1, 0, 0, 0, 0, "t3s_lock_nowrap");
    step(0, 2'd1, 0, 1, 0, 0, 0, 0, "t3s_l1");
    step(0, 2'd1, 0, 0, 0, 0, 1, 3, "t3s_stall");
    step(0, 2'd2, 0, 0, 0, 0, 1, 3, "t3s_frozen");
    // Error during acquisition restarts the good count, no sticky flag
    step(0, 2'd2, 1, 0, 0, 0, 0, 0, "t4_clr");
    step(0, 2'd2, 0, 0, 0, 0, 0, 0, "t4_idle");
    step(0, 2'd0, 0, 0, 0, 0, 0, 0, "t4_g1");
    step(0, 2'd1, 0, 0, 0, 0, 0, 0, "t4_g2");
    step(0, 2'd0, 0, 0, 0, 0, 0, 0, "t4_acq_err");
    step(0, 2'd1, 0, 0, 0, 0, 0, 0, "t4_r1");
    step(0, 2'd2, 0, 0, 0, 0, 0, 0, "t4_r2");
    step(0, 2'd0, 0, 0, 0, 0, 0, 0, "t4_r3");
    step(0, 2'd1, 0, 1, 0, 0, 0, 0, "t4_r4_lock");

    // Asynchronous reset mid-cycle on instance A
    @(negedge clk);
    #2 rst_a = 1'b0;
    #1 check("async_rst_a", act_a(), 21'd0);

    // Saturation with PCW=4: 20 periods while locked
    @(posedge clk);
    #2 rst_b = 1'b1;
    for (int k = 0; k <= 64; k++) begin
      p = (k >= 3) ? (k - 3) / 3 : 0;
      if (p > 15) p = 15;
      step(1, 2'(k % 3), 0, (k >= 4), (k >= 6 && (k % 3) == 0), p, 0, 0, "t6_sat");
    end

    // Asynchronous reset mid-period on instance B
    @(negedge clk);
    #2 rst_b = 1'b0;
    #1 check("async_rst_b", act_b(), 21'd0);

    @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
